// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   RV32I instruction-decode stage between fetch and execute.
//   IF/ID register holds the fetched instruction and drives the register-file
//   read ports; the returned operands (with write-back bypass), immediate and
//   control fields are captured into the ID/EX register.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
//   high; the sender holds its payload stable while valid && !ready, and ready
//   may depend combinationally on the receiver's state but never on the
//   sender's valid in the same cycle.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   in_valid/in_ready     fetch -> decode handshake, in_instr / in_pc payload
//   rd_en1/2, rd_addr1/2  register-file read request (combinational, IF/ID)
//   rd_data1/2            register-file read data (same-cycle return)
//   wb_en/wb_addr/wb_data write-back port, used for bypass
//   flush                 redirect from execute, kills both stages
//   out_valid/out_ready   decode -> execute handshake
//   out_*                 registered ID/EX payload
// -----------------------------------------------------------------------------
module decode_stage #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            rd_en1,
   output logic [4:0]      rd_addr1,
   output logic            rd_en2,
   output logic [4:0]      rd_addr2,
   input  logic [XLEN-1:0] rd_data1,
   input  logic [XLEN-1:0] rd_data2,
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [XLEN-1:0] out_imm,
   output logic [4:0]      out_rd,
   output logic [2:0]      out_funct3,
   output logic            out_funct7b5,
   output logic            out_is_load,
   output logic            out_is_store,
   output logic            out_is_branch,
   output logic            out_is_jal,
   output logic            out_is_jalr,
   output logic            out_is_lui,
   output logic            out_is_auipc,
   output logic            out_is_op,
   output logic            out_is_opimm,
   output logic            out_wb_en,
   output logic            out_illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic            is_load;
      logic            is_store;
      logic            is_branch;
      logic            is_jal;
      logic            is_jalr;
      logic            is_lui;
      logic            is_auipc;
      logic            is_op;
      logic            is_opimm;
      logic            wb_en;
      logic            illegal;
   } ex_t;

   // IF/ID register
   logic            d_valid_q, d_valid_d;
   logic [31:0]     d_instr_q, d_instr_d;
   logic [XLEN-1:0] d_pc_q, d_pc_d;
   // ID/EX register
   ex_t             ex_q, ex_d;
   // Holds in_ready low until the first edge after reset release
   logic            rdy_q, rdy_d;

   // Combinational decode of the IF/ID instruction
   ex_t             dec;
   logic [6:0]      opcode;
   logic [4:0]      rs1, rs2;
   logic            uses_rs1, uses_rs2, writes_rd;
   logic            haz, ex_free, advance, accept;

   always_comb begin
      opcode        = d_instr_q[6:0];
      rs1           = d_instr_q[19:15];
      rs2           = d_instr_q[24:20];

      dec           = '0;
      dec.valid     = d_valid_q;
      dec.pc        = d_pc_q;
      dec.rd        = d_instr_q[11:7];
      dec.funct3    = d_instr_q[14:12];
      dec.funct7b5  = d_instr_q[30];
      dec.is_lui    = (opcode == OPC_LUI);
      dec.is_auipc  = (opcode == OPC_AUIPC);
      dec.is_jal    = (opcode == OPC_JAL);
      dec.is_jalr   = (opcode == OPC_JALR);
      dec.is_branch = (opcode == OPC_BRANCH);
      dec.is_load   = (opcode == OPC_LOAD);
      dec.is_store  = (opcode == OPC_STORE);
      dec.is_opimm  = (opcode == OPC_OPIMM);
      dec.is_op     = (opcode == OPC_OP);
      dec.illegal   = !(dec.is_lui || dec.is_auipc || dec.is_jal || dec.is_jalr ||
                        dec.is_branch || dec.is_load || dec.is_store ||
                        dec.is_opimm || dec.is_op);

      uses_rs1  = dec.is_jalr || dec.is_branch || dec.is_load || dec.is_store ||
                  dec.is_opimm || dec.is_op;
      uses_rs2  = dec.is_branch || dec.is_store || dec.is_op;
      writes_rd = dec.is_lui || dec.is_auipc || dec.is_jal || dec.is_jalr ||
                  dec.is_load || dec.is_opimm || dec.is_op;
      dec.wb_en = writes_rd && (dec.rd != 5'd0);

      if (dec.is_jalr || dec.is_load || dec.is_opimm)
         dec.imm = {{(XLEN-12){d_instr_q[31]}}, d_instr_q[31:20]};
      else if (dec.is_store)
         dec.imm = {{(XLEN-12){d_instr_q[31]}}, d_instr_q[31:25], d_instr_q[11:7]};
      else if (dec.is_branch)
         dec.imm = {{(XLEN-13){d_instr_q[31]}}, d_instr_q[31], d_instr_q[7],
                    d_instr_q[30:25], d_instr_q[11:8], 1'b0};
      else if (dec.is_lui || dec.is_auipc)
         dec.imm = {{(XLEN-32){d_instr_q[31]}}, d_instr_q[31:12], 12'b0};
      else if (dec.is_jal)
         dec.imm = {{(XLEN-21){d_instr_q[31]}}, d_instr_q[31], d_instr_q[19:12],
                    d_instr_q[20], d_instr_q[30:21], 1'b0};
      else
         dec.imm = '0;

      // x0 wins over bypass, bypass wins over the register file
      if (!uses_rs1 || rs1 == 5'd0)       dec.rs1_data = '0;
      else if (wb_en && wb_addr == rs1)   dec.rs1_data = wb_data;
      else                                dec.rs1_data = rd_data1;

      if (!uses_rs2 || rs2 == 5'd0)       dec.rs2_data = '0;
      else if (wb_en && wb_addr == rs2)   dec.rs2_data = wb_data;
      else                                dec.rs2_data = rd_data2;
   end

   assign rd_en1   = d_valid_q && uses_rs1;
   assign rd_en2   = d_valid_q && uses_rs2;
   assign rd_addr1 = d_valid_q ? rs1 : 5'd0;
   assign rd_addr2 = d_valid_q ? rs2 : 5'd0;

   // A load sitting in ID/EX cannot forward its data in time to the consumer
   assign haz = d_valid_q && ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) &&
                ((rd_en1 && ex_q.rd == rs1) || (rd_en2 && ex_q.rd == rs2));

   assign ex_free  = !ex_q.valid || out_ready;
   assign advance  = ex_free && !haz;
   assign in_ready = rdy_q && (!d_valid_q || advance);
   assign accept   = in_valid && in_ready;

   always_comb begin
      d_valid_d = d_valid_q;
      d_instr_d = d_instr_q;
      d_pc_d    = d_pc_q;
      ex_d      = ex_q;
      rdy_d     = 1'b1;

      if (ex_free) begin
         if (haz) ex_d.valid = 1'b0;
         else     ex_d       = dec;
      end

      if (advance) d_valid_d = 1'b0;
      if (accept) begin
         d_valid_d = 1'b1;
         d_instr_d = in_instr;
         d_pc_d    = in_pc;
      end

      if (flush) begin
         d_valid_d  = 1'b0;
         ex_d.valid = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d_valid_q <= 1'b0;
         d_instr_q <= '0;
         d_pc_q    <= '0;
         ex_q      <= '0;
         ex_q.pc   <= RESET_PC;
         rdy_q     <= 1'b0;
      end else begin
         d_valid_q <= d_valid_d;
         d_instr_q <= d_instr_d;
         d_pc_q    <= d_pc_d;
         ex_q      <= ex_d;
         rdy_q     <= rdy_d;
      end
   end

   assign out_valid     = ex_q.valid;
   assign out_pc        = ex_q.pc;
   assign out_rs1_data  = ex_q.rs1_data;
   assign out_rs2_data  = ex_q.rs2_data;
   assign out_imm       = ex_q.imm;
   assign out_rd        = ex_q.rd;
   assign out_funct3    = ex_q.funct3;
   assign out_funct7b5  = ex_q.funct7b5;
   assign out_is_load   = ex_q.is_load;
   assign out_is_store  = ex_q.is_store;
   assign out_is_branch = ex_q.is_branch;
   assign out_is_jal    = ex_q.is_jal;
   assign out_is_jalr   = ex_q.is_jalr;
   assign out_is_lui    = ex_q.is_lui;
   assign out_is_auipc  = ex_q.is_auipc;
   assign out_is_op     = ex_q.is_op;
   assign out_is_opimm  = ex_q.is_opimm;
   assign out_wb_en     = ex_q.wb_en;
   assign out_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Self-checking bench for decode_stage. Expected ID/EX records are pushed when
//   an instruction is accepted and popped by the monitor when execute takes it;
//   each scenario task also checks its own timing-sensitive behaviour inline.
// -----------------------------------------------------------------------------
module tb_decode_stage;

   localparam logic [8:0] C_LOAD   = 9'b100000000;
   localparam logic [8:0] C_STORE  = 9'b010000000;
   localparam logic [8:0] C_BRANCH = 9'b001000000;
   localparam logic [8:0] C_JAL    = 9'b000100000;
   localparam logic [8:0] C_JALR   = 9'b000010000;
   localparam logic [8:0] C_LUI    = 9'b000001000;
   localparam logic [8:0] C_AUIPC  = 9'b000000100;
   localparam logic [8:0] C_OP     = 9'b000000010;
   localparam logic [8:0] C_OPIMM  = 9'b000000001;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [8:0]  cls;
      logic        wb_en;
      logic        illegal;
      logic [2:0]  funct3;
      logic        funct7b5;
   } exp_t;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [31:0] in_instr, in_pc;
   logic        rd_en1, rd_en2;
   logic [4:0]  rd_addr1, rd_addr2;
   logic [31:0] rd_data1, rd_data2;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
   logic [4:0]  out_rd;
   logic [2:0]  out_funct3;
   logic        out_funct7b5;
   logic        out_is_load, out_is_store, out_is_branch, out_is_jal, out_is_jalr;
   logic        out_is_lui, out_is_auipc, out_is_op, out_is_opimm;
   logic        out_wb_en, out_illegal;
   logic [8:0]  out_cls;

   logic [31:0] rf [32];
   exp_t        exp_q [$];
   exp_t        sb_e;
   int          checks = 0, errors = 0;
   int          sb_checks = 0, sb_errors = 0;

   always #5 clk = ~clk;

   assign rd_data1 = rf[rd_addr1];
   assign rd_data2 = rf[rd_addr2];
   assign out_cls  = {out_is_load, out_is_store, out_is_branch, out_is_jal, out_is_jalr,
                      out_is_lui, out_is_auipc, out_is_op, out_is_opimm};

   decode_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .rd_en1(rd_en1), .rd_addr1(rd_addr1), .rd_en2(rd_en2), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
      .out_rd(out_rd), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
      .out_is_load(out_is_load), .out_is_store(out_is_store), .out_is_branch(out_is_branch),
      .out_is_jal(out_is_jal), .out_is_jalr(out_is_jalr), .out_is_lui(out_is_lui),
      .out_is_auipc(out_is_auipc), .out_is_op(out_is_op), .out_is_opimm(out_is_opimm),
      .out_wb_en(out_wb_en), .out_illegal(out_illegal)
   );

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         sb_checks++;
         if (exp_q.size() == 0) begin
            sb_errors++;
            $display("FAIL sb_unexpected: out_valid with pc=%h, expected no output", out_pc);
         end else begin
            sb_e = exp_q.pop_front();
            if (out_pc !== sb_e.pc || out_rs1_data !== sb_e.rs1 || out_rs2_data !== sb_e.rs2 ||
                out_imm !== sb_e.imm || out_cls !== sb_e.cls || out_wb_en !== sb_e.wb_en ||
                out_illegal !== sb_e.illegal || out_funct3 !== sb_e.funct3 ||
                out_funct7b5 !== sb_e.funct7b5 || (sb_e.wb_en && out_rd !== sb_e.rd)) begin
               sb_errors++;
               $display("FAIL sb_record: got pc=%h rs1=%h rs2=%h imm=%h rd=%0d cls=%b wb=%b ill=%b f3=%0d f7=%b, exp pc=%h rs1=%h rs2=%h imm=%h rd=%0d cls=%b wb=%b ill=%b f3=%0d f7=%b",
                        out_pc, out_rs1_data, out_rs2_data, out_imm, out_rd, out_cls, out_wb_en,
                        out_illegal, out_funct3, out_funct7b5, sb_e.pc, sb_e.rs1, sb_e.rs2,
                        sb_e.imm, sb_e.rd, sb_e.cls, sb_e.wb_en, sb_e.illegal, sb_e.funct3,
                        sb_e.funct7b5);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   function automatic exp_t mk(input logic [31:0] pc, rs1, rs2, imm, input logic [4:0] rd,
                               input logic [8:0] cls, input logic wbe, ill,
                               input logic [2:0] f3, input logic f7);
      exp_t e;
      e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.rd = rd; e.cls = cls;
      e.wb_en = wbe; e.illegal = ill; e.funct3 = f3; e.funct7b5 = f7;
      return e;
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Offers one instruction; returns 1 time unit after the accepting edge.
   task automatic drive(input logic [31:0] instr, pc, input exp_t e, output int waited);
      in_valid = 1'b1; in_instr = instr; in_pc = pc; waited = 0;
      #1;
      while (!in_ready && waited < 20) begin
         @(posedge clk); #1; waited++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL drive_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waited);
      end else begin
         exp_q.push_back(e);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h10;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0 || out_pc !== 32'h0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: out_valid=%b out_pc=%h in_ready=%b, required 0/0/0",
                     out_valid, out_pc, in_ready);
         end
      end
      reset = 1'b1; in_valid = 1'b0;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || rd_en1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b out_valid=%b rd_en1=%b, required 1/0/0",
                  in_ready, out_valid, rd_en1);
      end
   endtask

   task automatic test_addi();
      int w;
      out_ready = 1'b1;
      drive(32'h0050_0093, 32'h10, mk(32'h10, 0, 0, 5, 1, C_OPIMM, 1, 0, 3'd0, 0), w);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_imm !== 32'd5 || out_rd !== 5'd1 || out_rs1_data !== 32'd0 ||
          out_is_opimm !== 1'b1 || out_wb_en !== 1'b1) begin
         errors++;
         $display("FAIL addi_latency: valid=%b imm=%h rd=%0d rs1=%h opimm=%b wb=%b, required 1/5/1/0/1/1",
                  out_valid, out_imm, out_rd, out_rs1_data, out_is_opimm, out_wb_en);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL addi_drain: out_valid=%b, required 0", out_valid);
      end
   endtask

   task automatic test_bypass();
      int w;
      rf[1] = 32'h0; wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hbeef_dead;
      drive(32'h0020_81B3, 32'h20, mk(32'h20, 32'hbeef_dead, rf[2], 0, 3, C_OP, 1, 0, 3'd0, 0), w);
      step();
      checks++;
      if (out_rs1_data !== 32'hbeef_dead || out_rs2_data !== rf[2]) begin
         errors++;
         $display("FAIL bypass_hit: rs1=%h rs2=%h, required beefdead/%h", out_rs1_data, out_rs2_data, rf[2]);
      end
      // x0 must read as zero even with a matching write-back and a non-zero array entry
      rf[0] = 32'h5555_5555; wb_addr = 5'd0; wb_data = 32'hdead_beef;
      drive(32'h0020_01B3, 32'h24, mk(32'h24, 0, rf[2], 0, 3, C_OP, 1, 0, 3'd0, 0), w);
      step();
      checks++;
      if (out_rs1_data !== 32'h0) begin
         errors++;
         $display("FAIL bypass_x0: rs1=%h, required 00000000", out_rs1_data);
      end
      step();
      rf[0] = 32'h0; rf[1] = 32'h1000_0001; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
   endtask

   task automatic test_load_use();
      int w;
      out_ready = 1'b1;
      drive(32'h0000_A103, 32'h40, mk(32'h40, rf[1], 0, 0, 2, C_LOAD, 1, 0, 3'd2, 0), w);
      drive(32'h0021_01B3, 32'h44, mk(32'h44, rf[2], rf[2], 0, 3, C_OP, 1, 0, 3'd0, 0), w);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_is_load !== 1'b1) begin
         errors++;
         $display("FAIL loaduse_stall: in_ready=%b out_valid=%b is_load=%b, required 0/1/1",
                  in_ready, out_valid, out_is_load);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL loaduse_bubble: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_is_op !== 1'b1) begin
         errors++;
         $display("FAIL loaduse_resume: out_valid=%b rd=%0d is_op=%b, required 1/3/1",
                  out_valid, out_rd, out_is_op);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] instrs [6];
      exp_t        exps [6];
      int          w;
      out_ready = 1'b1;
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hAAAA_5555;
      instrs[0] = 32'h1234_53B7; exps[0] = mk(32'h100, 0, 0, 32'h1234_5000, 7, C_LUI, 1, 0, 3'd5, 0);
      instrs[1] = 32'hFFFF_F417; exps[1] = mk(32'h104, 0, 0, 32'hFFFF_F000, 8, C_AUIPC, 1, 0, 3'd7, 1);
      instrs[2] = 32'hFF9F_F0EF; exps[2] = mk(32'h108, 0, 0, 32'hFFFF_FFF8, 1, C_JAL, 1, 0, 3'd7, 1);
      instrs[3] = 32'h0022_A623; exps[3] = mk(32'h10C, rf[5], rf[2], 32'd12, 0, C_STORE, 0, 0, 3'd2, 0);
      instrs[4] = 32'h0040_8067; exps[4] = mk(32'h110, rf[1], 0, 32'd4, 0, C_JALR, 0, 0, 3'd0, 0);
      instrs[5] = 32'hFFF0_8493; exps[5] = mk(32'h114, rf[1], 0, 32'hFFFF_FFFF, 9, C_OPIMM, 1, 0, 3'd0, 1);
      for (int i = 0; i < 6; i++) begin
         drive(instrs[i], exps[i].pc, exps[i], w);
         checks++;
         if (w != 0) begin
            errors++;
            $display("FAIL b2b_throughput[%0d]: waited %0d cycles, required 0", i, w);
         end
      end
      repeat (3) step();
      wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain: %0d records outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_imm_illegal();
      int w;
      out_ready = 1'b1;
      // B-immediate of 0xFE000EE3: imm[12]=1, imm[11]=instr[7]=1, imm[10:5]=111111, imm[4:1]=1110 -> -4
      drive(32'hFE00_0EE3, 32'h60, mk(32'h60, 0, 0, 32'hFFFF_FFFC, 0, C_BRANCH, 0, 0, 3'd0, 1), w);
      step();
      checks++;
      if (out_imm !== 32'hFFFF_FFFC || out_is_branch !== 1'b1 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL imm_b_neg4: imm=%h branch=%b valid=%b, required fffffffc/1/1", out_imm, out_is_branch, out_valid);
      end
      // Same with instr[7]=0 so imm[11] clears -> 0xFFFFF7FC
      drive(32'hFE00_0E63, 32'h64, mk(32'h64, 0, 0, 32'hFFFF_F7FC, 0, C_BRANCH, 0, 0, 3'd0, 1), w);
      step();
      checks++;
      if (out_imm !== 32'hFFFF_F7FC || out_is_branch !== 1'b1) begin
         errors++;
         $display("FAIL imm_b_bit11: imm=%h branch=%b, required fffff7fc/1", out_imm, out_is_branch);
      end
      drive(32'hFFFF_FFFF, 32'h68, mk(32'h68, 0, 0, 0, 0, 9'b0, 0, 1, 3'd7, 1), w);
      step();
      checks++;
      if (out_illegal !== 1'b1 || out_cls !== 9'b0 || out_imm !== 32'h0 || out_wb_en !== 1'b0) begin
         errors++;
         $display("FAIL illegal: ill=%b cls=%b imm=%h wb=%b, required 1/000000000/0/0",
                  out_illegal, out_cls, out_imm, out_wb_en);
      end
      step();
   endtask

   task automatic test_backpressure_flush();
      int w;
      out_ready = 1'b0;
      drive(32'h0050_0093, 32'h50, mk(32'h50, 0, 0, 5, 1, C_OPIMM, 1, 0, 3'd0, 0), w);
      drive(32'h0070_0293, 32'h54, mk(32'h54, 0, 0, 7, 5, C_OPIMM, 1, 0, 3'd0, 0), w);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'h50 || out_imm !== 32'd5 || out_rd !== 5'd1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: valid=%b pc=%h imm=%h rd=%0d in_ready=%b, required 1/50/5/1/0",
                     i, out_valid, out_pc, out_imm, out_rd, in_ready);
         end
         step();
      end
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0090_0313; in_pc = 32'h58;
      step();
      flush = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || rd_en1 !== 1'b0) begin
         errors++;
         $display("FAIL flush_full: out_valid=%b in_ready=%b rd_en1=%b, required 0/1/0", out_valid, in_ready, rd_en1);
      end
      // Flush while empty and ready: the offered instruction must still be dropped
      out_ready = 1'b1;
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0090_0313; in_pc = 32'h5C;
      step();
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (rd_en1 !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_drop: rd_en1=%b out_valid=%b, required 0/0", rd_en1, out_valid);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_quiet[%0d]: out_valid=%b, required 0", i, out_valid);
         end
      end
   endtask

   task automatic test_reset_midstream();
      int w;
      out_ready = 1'b0;
      drive(32'h0050_0093, 32'h70, mk(32'h70, 0, 0, 5, 1, C_OPIMM, 1, 0, 3'd0, 0), w);
      drive(32'h0070_0293, 32'h74, mk(32'h74, 0, 0, 7, 5, C_OPIMM, 1, 0, 3'd0, 0), w);
      #2 reset = 1'b0;
      #1;
      exp_q.delete();
      checks++;
      if (out_valid !== 1'b0 || out_pc !== 32'h0 || rd_en1 !== 1'b0 || out_wb_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: out_valid=%b pc=%h rd_en1=%b wb=%b, required 0/0/0/0",
                  out_valid, out_pc, rd_en1, out_wb_en);
      end
      step(); step();
      reset = 1'b1; out_ready = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
      end
      step();
   endtask

   // ---------------- main sequence and report ----------------
   initial begin
      reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b0;
      rf[0] = 32'h0;
      for (int i = 1; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
      test_reset();
      test_addi();
      test_bypass();
      test_load_use();
      test_back_to_back();
      test_imm_illegal();
      test_backpressure_flush();
      test_reset_midstream();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_queue: %0d records outstanding, required 0", exp_q.size());
      end
      checks = checks + sb_checks;
      errors = errors + sb_errors;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation exceeded 100000 time units");
      $fatal(1);
   end

endmodule
